// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite constants, data-phase state encoding and the little-endian byte-lane helper.
package ahb_lite_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'd0;
   localparam logic [1:0] HTRANS_BUSY   = 2'd1;
   localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
   localparam logic [1:0] HTRANS_SEQ    = 2'd3;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [2:0] {
      DP_IDLE,
      DP_DATA,
      DP_WAIT,
      DP_ERR1,
      DP_ERR2
   } dphase_state_e;

   function automatic logic [3:0] lane_mask(input logic [1:0] addr, input logic [2:0] size);
      logic [3:0] mask;
      case (size)
         HSIZE_BYTE: mask = 4'b0001 << addr;
         HSIZE_HALF: mask = addr[1] ? 4'b1100 : 4'b0011;
         default:    mask = 4'b1111;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/ahb_lite_sram_slave_if.sv
// AHB-Lite bus bundle between the system-port bridge (master) and the SRAM slave.
interface ahb_lite_sram_slave_if #(
   parameter int ADDR_W = 31
);
   logic              hsel;
   logic [1:0]        htrans;
   logic              hwrite;
   logic [2:0]        hsize;
   logic [2:0]        hburst;
   logic [3:0]        hprot;
   logic [ADDR_W-1:0] haddr;
   logic [31:0]       hwdata;
   logic              hready;
   logic              hreadyout;
   logic              hresp;
   logic [31:0]       hrdata;

   modport master (
      output hsel, htrans, hwrite, hsize, hburst, hprot, haddr, hwdata, hready,
      input  hreadyout, hresp, hrdata
   );

   modport slave (
      input  hsel, htrans, hwrite, hsize, hburst, hprot, haddr, hwdata, hready,
      output hreadyout, hresp, hrdata
   );
endinterface

// File: rtl/ahb_sram_bank.sv
// Plain word-wide SRAM with per-byte write enables and a registered read port; no bus knowledge.
module ahb_sram_bank #(
   parameter  int MEM_BYTES = 4096,
   localparam int WORDS     = MEM_BYTES / 4,
   localparam int IDX_W     = $clog2(WORDS)
) (
   input  logic             clock,
   input  logic             rd_en,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [31:0]      rd_data,
   input  logic [3:0]       wr_be,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [31:0]      wr_data
);

   logic [31:0] mem_q [WORDS];
   logic [31:0] rd_data_q;

   // Read-during-write to the same word returns the old contents; the parent bypasses.
   always_ff @(posedge clock) begin
      if (rd_en) begin
         rd_data_q <= mem_q[rd_idx];
      end
      for (int b = 0; b < 4; b++) begin
         if (wr_be[b]) begin
            mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite slave fronting a local SRAM window with RAW bypass and two-cycle ERROR response.
// Optional data-phase wait states are enabled by defining AHB_SRAM_WAITSTATE_EN.
module ahb_lite_sram_slave
   import ahb_lite_pkg::*;
#(
   parameter int              ADDR_W      = 31,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 'h2000_0000,
   parameter int              MEM_BYTES   = 4096,
   parameter int              WAIT_CYCLES = 1
) (
   input logic                 clock,
   input logic                 reset,
   ahb_lite_sram_slave_if.slave bus
);

   localparam int IDX_W = $clog2(MEM_BYTES / 4);

   dphase_state_e     state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [3:0]        mask_q, mask_d;
   logic              write_q, write_d;
   logic [3:0]        byp_mask_q, byp_mask_d;
   logic [31:0]       byp_data_q, byp_data_d;
   logic              hreadyout_q, hreadyout_d;
   logic              hresp_q, hresp_d;

   logic [ADDR_W-1:0] offset;
   logic [IDX_W-1:0]  req_idx;
   logic              size_ok, align_ok, range_ok, req_valid;
   logic              accept, commit;
   logic [31:0]       bank_rdata;
   logic [31:0]       hrdata_mux;
   logic              unused_ok;

`ifdef AHB_SRAM_WAITSTATE_EN
   logic [3:0]        cnt_q, cnt_d;
`else
   localparam int unused_wait_cycles = WAIT_CYCLES;
`endif

   assign unused_ok = ^{bus.hburst, bus.hprot};

   // BASE_ADDR is aligned to the window, so offset[1:0] equals the byte-lane address.
   assign offset    = bus.haddr - BASE_ADDR;
   assign req_idx   = offset[IDX_W+1:2];
   assign size_ok   = bus.hsize <= HSIZE_WORD;
   assign align_ok  = (bus.hsize == HSIZE_BYTE)
                   || (bus.hsize == HSIZE_HALF && !offset[0])
                   || (offset[1:0] == 2'b00);
   assign range_ok  = offset < ADDR_W'(MEM_BYTES);
   assign req_valid = size_ok && align_ok && range_ok;

   // The second ERROR cycle shows hreadyout=1, but its address phase must be dropped.
   assign accept = bus.hsel && bus.htrans[1] && bus.hready && (state_q != DP_ERR2);
   assign commit = (state_q == DP_DATA) && write_q;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      mask_d     = mask_q;
      write_d    = write_q;
      byp_mask_d = byp_mask_q;
      byp_data_d = byp_data_q;
`ifdef AHB_SRAM_WAITSTATE_EN
      cnt_d      = cnt_q;
`endif
      case (state_q)
`ifdef AHB_SRAM_WAITSTATE_EN
         DP_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = DP_DATA;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
`endif
         DP_ERR1: state_d = DP_ERR2;
         default: state_d = DP_IDLE;
      endcase

      if (accept) begin
         idx_d      = req_idx;
         mask_d     = lane_mask(offset[1:0], bus.hsize);
         write_d    = bus.hwrite;
         // Capture the lanes of a write committing on this same edge to the word being read.
         byp_mask_d = (commit && (idx_q == req_idx)) ? mask_q : 4'b0000;
         byp_data_d = bus.hwdata;
         if (!req_valid) begin
            state_d = DP_ERR1;
         end else begin
`ifdef AHB_SRAM_WAITSTATE_EN
            if (WAIT_CYCLES == 0) begin
               state_d = DP_DATA;
            end else begin
               state_d = DP_WAIT;
               cnt_d   = 4'(WAIT_CYCLES - 1);
            end
`else
            state_d = DP_DATA;
`endif
         end
      end

      hreadyout_d = !((state_d == DP_WAIT) || (state_d == DP_ERR1));
      hresp_d     = ((state_d == DP_ERR1) || (state_d == DP_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= DP_IDLE;
         idx_q       <= '0;
         mask_q      <= 4'b0000;
         write_q     <= 1'b0;
         byp_mask_q  <= 4'b0000;
         byp_data_q  <= '0;
         hreadyout_q <= 1'b1;
         hresp_q     <= HRESP_OKAY;
`ifdef AHB_SRAM_WAITSTATE_EN
         cnt_q       <= 4'd0;
`endif
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         mask_q      <= mask_d;
         write_q     <= write_d;
         byp_mask_q  <= byp_mask_d;
         byp_data_q  <= byp_data_d;
         hreadyout_q <= hreadyout_d;
         hresp_q     <= hresp_d;
`ifdef AHB_SRAM_WAITSTATE_EN
         cnt_q       <= cnt_d;
`endif
      end
   end

   ahb_sram_bank #(
      .MEM_BYTES (MEM_BYTES)
   ) u_bank (
      .clock   (clock),
      .rd_en   (accept && req_valid && !bus.hwrite),
      .rd_idx  (req_idx),
      .rd_data (bank_rdata),
      .wr_be   (commit ? mask_q : 4'b0000),
      .wr_idx  (idx_q),
      .wr_data (bus.hwdata)
   );

   always_comb begin
      hrdata_mux = '0;
      if ((state_q == DP_DATA) && !write_q) begin
         for (int b = 0; b < 4; b++) begin
            hrdata_mux[8*b +: 8] = byp_mask_q[b] ? byp_data_q[8*b +: 8] : bank_rdata[8*b +: 8];
         end
      end
   end

   assign bus.hreadyout = hreadyout_q;
   assign bus.hresp     = hresp_q;
   assign bus.hrdata    = hrdata_mux;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Self-checking bench for ahb_lite_sram_slave: directed scenarios plus random pipelined traffic
// checked against a byte-array model of the SRAM window. Honours AHB_SRAM_WAITSTATE_EN.
`timescale 1ns/1ps
module tb_ahb_lite_sram_slave;

   localparam int          ADDR_W    = 31;
   localparam logic [30:0] BASE      = 31'h2000_0000;
   localparam int          MEM_BYTES = 4096;
   localparam int          WORDS     = MEM_BYTES / 4;
`ifdef AHB_SRAM_WAITSTATE_EN
   localparam int          EXP_WAITS = 2;
`else
   localparam int          EXP_WAITS = 0;
`endif
   localparam logic [1:0]  T_IDLE = 2'd0, T_BUSY = 2'd1, T_NONSEQ = 2'd2, T_SEQ = 2'd3;

   logic clock = 1'b0;
   logic reset;
   int   n_cmp  = 0;
   int   n_fail = 0;

   ahb_lite_sram_slave_if #(.ADDR_W(ADDR_W)) bus ();
   assign bus.hready = bus.hreadyout;

   ahb_lite_sram_slave #(
      .ADDR_W      (ADDR_W),
      .BASE_ADDR   (BASE),
      .MEM_BYTES   (MEM_BYTES),
      .WAIT_CYCLES (2)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // Reference state: byte image of the window and the transfer currently in its data phase.
   logic [7:0]  model_mem [MEM_BYTES];
   logic        p_valid, p_err, p_wr;
   logic [2:0]  p_sz;
   logic [30:0] p_addr;
   logic [31:0] p_wdata;
   logic [31:0] last_rdata;
   logic [31:0] snap;

   function automatic logic is_valid(input logic [2:0] sz, input logic [30:0] addr);
      logic [30:0] off;
      off = addr - BASE;
      if (sz > 3'd2) return 1'b0;
      if ((addr % (31'd1 << sz)) != 31'd0) return 1'b0;
      return off < 31'(MEM_BYTES);
   endfunction

   function automatic logic [31:0] model_word(input logic [30:0] addr);
      int b;
      b = int'(addr - BASE);
      b = b - (b % 4);
      return {model_mem[b+3], model_mem[b+2], model_mem[b+1], model_mem[b]};
   endfunction

   task automatic model_write(input logic [30:0] addr, input logic [2:0] sz, input logic [31:0] wdata);
      int off, lane;
      off  = int'(addr - BASE);
      lane = off % 4;
      for (int i = 0; i < (1 << sz); i++) begin
         model_mem[off + i] = wdata[8*(lane + i) +: 8];
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Presents one address phase while the previous transfer finishes its data phase, then
   // checks that completing transfer. Entered and left on a falling edge.
   task automatic applyStimulus(input logic sel, input logic [1:0] trans, input logic wr,
                                input logic [2:0] sz, input logic [30:0] addr, input logic [31:0] wdata);
      int   waits;
      logic stall_ok, exp_err;
      exp_err     = p_valid && p_err;
      bus.hsel    = sel;
      bus.htrans  = trans;
      bus.hwrite  = wr;
      bus.hsize   = sz;
      bus.haddr   = addr;
      bus.hburst  = 3'($urandom);
      bus.hprot   = 4'($urandom);
      bus.hwdata  = (p_valid && p_wr) ? p_wdata : $urandom;
      waits       = 0;
      stall_ok    = 1'b1;
      while (bus.hreadyout !== 1'b1 && waits < 16) begin
         if (bus.hresp !== exp_err) stall_ok = 1'b0;
         @(negedge clock);
         waits++;
      end
      checkOutput("wait_states", 32'(waits), 32'(!p_valid ? 0 : (p_err ? 1 : EXP_WAITS)));
      if (waits > 0) checkOutput("stall_hresp", {31'd0, stall_ok}, 32'd1);
      checkOutput("hresp", {31'd0, bus.hresp}, {31'd0, exp_err});
      if (p_valid && (p_err || !p_wr)) begin
         last_rdata = bus.hrdata;
         checkOutput(p_err ? "err_hrdata" : "read_data", bus.hrdata, p_err ? 32'd0 : model_word(p_addr));
      end
      if (p_valid && !p_err && p_wr) model_write(p_addr, p_sz, p_wdata);
      p_valid = sel && trans[1] && !exp_err;
      p_err   = !is_valid(sz, addr);
      p_wr    = wr;
      p_sz    = sz;
      p_addr  = addr;
      p_wdata = wdata;
      @(negedge clock);
   endtask

   initial begin
      logic [1:0]  tr;
      logic [2:0]  sz;
      logic [30:0] a;
      int          r;

      reset      = 1'b1;
      bus.hsel   = 1'b0;
      bus.htrans = T_IDLE;
      bus.hwrite = 1'b0;
      bus.hsize  = 3'd0;
      bus.hburst = 3'd0;
      bus.hprot  = 4'd0;
      bus.haddr  = '0;
      bus.hwdata = '0;
      p_valid    = 1'b0;
      p_err      = 1'b0;
      p_wr       = 1'b0;
      p_sz       = 3'd0;
      p_addr     = '0;
      p_wdata    = '0;
      last_rdata = '0;
      repeat (3) @(negedge clock);
      checkOutput("rst_hreadyout", {31'd0, bus.hreadyout}, 32'd1);
      checkOutput("rst_hresp", {31'd0, bus.hresp}, 32'd0);
      checkOutput("rst_hrdata", bus.hrdata, 32'd0);
      reset = 1'b0;
      @(negedge clock);

      $display("[TB] filling the window with a SEQ word burst");
      for (int i = 0; i < WORDS; i++)
         applyStimulus(1'b1, (i == 0) ? T_NONSEQ : T_SEQ, 1'b1, 3'd2, BASE + 31'(4 * i), $urandom);
      applyStimulus(1'b1, T_IDLE, 1'b0, 3'd0, BASE, 32'd0);

      $display("[TB] reset asserted during a write data phase");
      snap = model_word(BASE);
      applyStimulus(1'b1, T_NONSEQ, 1'b1, 3'd2, BASE, 32'h1234_5678);
      bus.hsel   = 1'b0;
      bus.htrans = T_IDLE;
      bus.hwdata = 32'h1234_5678;
      reset      = 1'b1;
      #1;
      checkOutput("midrst_hreadyout", {31'd0, bus.hreadyout}, 32'd1);
      checkOutput("midrst_hresp", {31'd0, bus.hresp}, 32'd0);
      checkOutput("midrst_hrdata", bus.hrdata, 32'd0);
      @(negedge clock);
      checkOutput("midrst_hold_hreadyout", {31'd0, bus.hreadyout}, 32'd1);
      reset   = 1'b0;
      p_valid = 1'b0;
      applyStimulus(1'b1, T_NONSEQ, 1'b0, 3'd2, BASE, 32'd0);
      applyStimulus(1'b1, T_IDLE, 1'b0, 3'd0, BASE, 32'd0);
      checkOutput("reset_dropped_write", last_rdata, snap);

      $display("[TB] write then back-to-back read of the same word");
      applyStimulus(1'b1, T_NONSEQ, 1'b1, 3'd2, BASE + 31'd4, 32'hDEAD_BEEF);
      applyStimulus(1'b1, T_NONSEQ, 1'b0, 3'd2, BASE + 31'd4, 32'd0);
      applyStimulus(1'b1, T_IDLE, 1'b0, 3'd0, BASE, 32'd0);
      checkOutput("raw_bypass_word", last_rdata, 32'hDEAD_BEEF);

      $display("[TB] byte and halfword lane writes");
      applyStimulus(1'b1, T_NONSEQ, 1'b1, 3'd2, BASE + 31'd4, 32'h1122_3344);
      applyStimulus(1'b1, T_NONSEQ, 1'b1, 3'd0, BASE + 31'd7, 32'hA500_0000);
      applyStimulus(1'b1, T_NONSEQ, 1'b0, 3'd2, BASE + 31'd4, 32'd0);
      applyStimulus(1'b1, T_IDLE, 1'b0, 3'd0, BASE, 32'd0);
      checkOutput("byte_lane3", last_rdata, 32'hA522_3344);
      applyStimulus(1'b1, T_NONSEQ, 1'b1, 3'd1, BASE + 31'd6, 32'hBEEF_0000);
      applyStimulus(1'b1, T_NONSEQ, 1'b0, 3'd2, BASE + 31'd4, 32'd0);
      applyStimulus(1'b1, T_IDLE, 1'b0, 3'd0, BASE, 32'd0);
      checkOutput("half_upper", last_rdata, 32'hBEEF_3344);

      $display("[TB] error transfers");
      applyStimulus(1'b1, T_NONSEQ, 1'b0, 3'd2, BASE + 31'(MEM_BYTES), 32'd0);
      applyStimulus(1'b1, T_NONSEQ, 1'b1, 3'd2, BASE + 31'd4, 32'hFFFF_FFFF);
      applyStimulus(1'b1, T_NONSEQ, 1'b1, 3'd1, BASE + 31'd5, 32'hFFFF_FFFF);
      applyStimulus(1'b1, T_IDLE, 1'b0, 3'd0, BASE, 32'd0);
      applyStimulus(1'b1, T_NONSEQ, 1'b0, 3'd1, BASE + 31'd1, 32'd0);
      applyStimulus(1'b1, T_IDLE, 1'b0, 3'd0, BASE, 32'd0);
      applyStimulus(1'b1, T_NONSEQ, 1'b1, 3'd3, BASE + 31'd4, 32'hFFFF_FFFF);
      applyStimulus(1'b1, T_IDLE, 1'b0, 3'd0, BASE, 32'd0);
      applyStimulus(1'b1, T_NONSEQ, 1'b1, 3'd2, BASE - 31'd4, 32'hFFFF_FFFF);
      applyStimulus(1'b1, T_IDLE, 1'b0, 3'd0, BASE, 32'd0);
      applyStimulus(1'b1, T_NONSEQ, 1'b0, 3'd2, BASE + 31'd4, 32'd0);
      applyStimulus(1'b1, T_IDLE, 1'b0, 3'd0, BASE, 32'd0);
      checkOutput("err_no_sram_change", last_rdata, 32'hBEEF_3344);

      $display("[TB] burst with IDLE, BUSY and deselected beats");
      snap = model_word(BASE + 31'h24);
      applyStimulus(1'b1, T_NONSEQ, 1'b1, 3'd2, BASE + 31'h20, 32'hC0DE_0001);
      applyStimulus(1'b1, T_BUSY,   1'b1, 3'd2, BASE + 31'h24, 32'hBAD0_0001);
      applyStimulus(1'b0, T_SEQ,    1'b1, 3'd2, BASE + 31'h24, 32'hBAD0_0002);
      applyStimulus(1'b1, T_IDLE,   1'b1, 3'd2, BASE + 31'h24, 32'hBAD0_0003);
      applyStimulus(1'b1, T_NONSEQ, 1'b0, 3'd2, BASE + 31'h24, 32'd0);
      applyStimulus(1'b1, T_IDLE,   1'b0, 3'd0, BASE, 32'd0);
      checkOutput("ignored_beats", last_rdata, snap);
      applyStimulus(1'b1, T_SEQ,    1'b1, 3'd2, BASE + 31'h24, 32'hC0DE_0002);
      applyStimulus(1'b1, T_NONSEQ, 1'b0, 3'd2, BASE + 31'h20, 32'd0);
      applyStimulus(1'b1, T_SEQ,    1'b0, 3'd2, BASE + 31'h24, 32'd0);
      applyStimulus(1'b1, T_IDLE,   1'b0, 3'd0, BASE, 32'd0);
      checkOutput("burst_last_beat", last_rdata, 32'hC0DE_0002);

      $display("[TB] random pipelined traffic");
      for (int k = 0; k < 400; k++) begin
         r  = $urandom_range(0, 99);
         tr = (r < 35) ? T_NONSEQ : (r < 70) ? T_SEQ : (r < 85) ? T_IDLE : T_BUSY;
         sz = ($urandom_range(0, 9) == 0) ? 3'(3 + $urandom_range(0, 4)) : 3'($urandom_range(0, 2));
         r  = $urandom_range(0, 11);
         if (r == 0)      a = BASE + 31'(MEM_BYTES) + 31'($urandom_range(0, 15));
         else if (r == 1) a = BASE - 31'd1 - 31'($urandom_range(0, 15));
         else if (r == 2) a = BASE + 31'(MEM_BYTES - 4) + 31'($urandom_range(0, 3));
         else             a = BASE + 31'($urandom_range(0, 31));
         if (sz <= 3'd2 && $urandom_range(0, 4) != 0) a = a & ~((31'd1 << sz) - 31'd1);
         applyStimulus($urandom_range(0, 9) != 0, tr, 1'($urandom), sz, a, $urandom);
      end
      applyStimulus(1'b1, T_IDLE, 1'b0, 3'd0, BASE, 32'd0);
      applyStimulus(1'b1, T_IDLE, 1'b0, 3'd0, BASE, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
